mem_store_buffer: RTL and testbench

Store buffer and load/store port arbiter between the memory stage and the unified `instruction_and_data` memory. It queues stores from the memory stage in a DEPTH-entry FIFO and drains them to memory whenever instruction fetch is not using the port. Loads that match a buffered store are forwarded from the buffer. Loads that miss are issued to memory ahead of pending drains, with a stall back to the pipeline.

---
 rtl/mem_store_buffer.sv | 179 +++++++++++++++++
 tb/tb_mem_store_buffer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// Store buffer and load/store arbiter in front of the unified memory port.
// Stores queue in a FIFO and drain when fetch leaves the port idle; loads
// forward from the youngest matching entry or are issued ahead of drains.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   writeIn, readIn               store / load request from the memory stage
//   addressIn, dataIn             request address and store data
//   stall                         hold the pipeline request constant
//   readData, readValid           load result and its one-cycle strobe
//   memBusy                       instruction fetch owns the port this cycle
//   memAddress, memData           memory port address / write data
//   memWrite, memRead             memory port strobes
//   memReadData                   memory read data, one cycle after memRead
//   count                         occupied buffer entries
module mem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              writeIn,
    input  logic              readIn,
    input  logic [ADDR_W-1:0] addressIn,
    input  logic [DATA_W-1:0] dataIn,
    output logic              stall,
    output logic [DATA_W-1:0] readData,
    output logic              readValid,
    input  logic              memBusy,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memData,
    output logic              memWrite,
    output logic              memRead,
    input  logic [DATA_W-1:0] memReadData,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LD_ISSUE,
        LD_DATA
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] ld_addr_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic              full, empty, is_idle;
    logic              load_req, enq, drain;
    logic              hit, fwd, miss, mem_rd;
    logic [DATA_W-1:0] hit_data;
    logic [PTR_W-1:0]  idx;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign is_idle  = (state_q == IDLE);
    // A simultaneous store and load is treated as a store only.
    assign load_req = readIn & ~writeIn;
    assign enq      = writeIn & ~full;

    // Walk entries oldest to youngest so the last match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addr_q[idx] == addressIn)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign fwd   = load_req & is_idle & hit;
    assign miss  = load_req & is_idle & ~hit;
    assign drain = is_idle & ~empty & ~memBusy & ~miss;

    always_comb begin
        state_d  = state_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        mem_rd   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d = LD_ISSUE;
                end
                if (fwd) begin
                    rvalid_d = 1'b1;
                    rdata_d  = hit_data;
                end
            end
            LD_ISSUE: begin
                if (!memBusy) begin
                    mem_rd  = 1'b1;
                    state_d = LD_DATA;
                end
            end
            LD_DATA: begin
                rvalid_d = 1'b1;
                rdata_d  = memReadData;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ld_addr_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            if (miss) begin
                ld_addr_q <= addressIn;
            end
            if (enq) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (drain) begin
                head_q <= head_q + PTR_W'(1);
            end
            unique case ({enq, drain})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset: validity comes from count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= addressIn;
            data_q[tail_q] <= dataIn;
        end
    end

    // A raw load request can still be high while reset is held, so the
    // stall term is masked to keep every output at zero during reset.
    assign stall = rst & ((writeIn & full) | miss | ~is_idle);

    assign memWrite = drain;
    assign memRead  = mem_rd;

    always_comb begin
        memAddress = '0;
        memData    = '0;
        if (drain) begin
            memAddress = addr_q[head_q];
            memData    = data_q[head_q];
        end else if (mem_rd) begin
            memAddress = ld_addr_q;
        end
    end

    assign readData  = rdata_q;
    assign readValid = rvalid_q;
    assign count     = count_q;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer: directed scenarios plus random
// traffic, checked every cycle against a queue-based model and program order.
module tb_mem_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          writeIn = 1'b0;
    logic          readIn = 1'b0;
    logic          memBusy = 1'b0;
    logic [AW-1:0] addressIn = '0;
    logic [DW-1:0] dataIn = '0;
    logic [DW-1:0] memReadData = '0;
    logic          stall, readValid, memWrite, memRead;
    logic [DW-1:0] readData, memData;
    logic [AW-1:0] memAddress;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    mem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .writeIn(writeIn), .readIn(readIn),
        .addressIn(addressIn), .dataIn(dataIn),
        .stall(stall), .readData(readData), .readValid(readValid),
        .memBusy(memBusy), .memAddress(memAddress), .memData(memData),
        .memWrite(memWrite), .memRead(memRead),
        .memReadData(memReadData), .count(count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference state: buffered stores in program order, load progress,
    // architectural (program-order) memory and the backing memory.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    int            ph = 0;
    logic [AW-1:0] ld_a = '0;
    logic          m_rv = 1'b0;
    logic [DW-1:0] m_rd = '0;
    logic [DW-1:0] ld_exp = '0;
    logic [DW-1:0] arch [logic [AW-1:0]];
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic          pend_rd = 1'b0;
    logic [AW-1:0] pend_ra = '0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a * 32'h9E37) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] rd_arch(input logic [AW-1:0] a);
        return arch.exists(a) ? arch[a] : init_val(a);
    endfunction

    // One cycle: called just after a rising edge, returns just after the next.
    task automatic step(input logic w, input logic r, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic busy,
                        output logic st);
        logic          full, hit, miss, e_mw, e_mr;
        logic [DW-1:0] hd, e_md;
        logic [AW-1:0] e_ma;
        writeIn   = w;
        readIn    = r;
        addressIn = a;
        dataIn    = d;
        memBusy   = busy;
        full = (q.size() == DEPTH);
        hit  = 1'b0;
        hd   = '0;
        if (ph == 0 && r && !w) begin
            foreach (q[i]) begin
                if (q[i].a == a) begin
                    hit = 1'b1;
                    hd  = q[i].d;
                end
            end
        end
        miss = (ph == 0) && r && !w && !hit;
        st   = (w && full) || miss || (ph != 0);
        e_mr = (ph == 1) && !busy;
        e_mw = (ph == 0) && (q.size() > 0) && !busy && !miss;
        e_ma = '0;
        e_md = '0;
        if (e_mw) begin
            e_ma = q[0].a;
            e_md = q[0].d;
        end else if (e_mr) begin
            e_ma = ld_a;
        end
        @(negedge clk);
        chk("stall", stall, st);
        chk("memWrite", memWrite, e_mw);
        chk("memRead", memRead, e_mr);
        chk("memAddress", memAddress, e_ma);
        chk("memData", memData, e_md);
        chk("count", count, q.size());
        chk("readValid", readValid, m_rv);
        if (m_rv) begin
            chk("readData", readData, m_rd);
            chk("load_value", readData, ld_exp);
        end
        pend_rd = memRead;
        pend_ra = memAddress;
        if (memWrite) mem[memAddress] = memData;
        if (hit) begin
            m_rv = 1'b1;
            m_rd = hd;
        end else if (ph == 2) begin
            m_rv = 1'b1;
            m_rd = memReadData;
        end else begin
            m_rv = 1'b0;
        end
        if (hit || miss) ld_exp = rd_arch(a);
        if (e_mw) void'(q.pop_front());
        if (w && !full) begin
            q.push_back('{a: a, d: d});
            arch[a] = d;
        end
        if (miss) begin
            ph   = 1;
            ld_a = a;
        end else if (ph == 1 && !busy) begin
            ph = 2;
        end else if (ph == 2) begin
            ph = 0;
        end
        @(posedge clk);
        #1;
        memReadData = pend_rd ? rd_mem(pend_ra) : $urandom;
    endtask

    task automatic idle(input int n, input logic busy);
        logic st;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, busy, st);
    endtask

    // Store held while stalled; memBusy high for the first nb attempts.
    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int nb, input logic r);
        logic st;
        int   k = 0;
        do begin
            step(1'b1, r, a, d, k < nb, st);
            k++;
        end while (st && k < 60);
        if (st) chk("store_timeout", 1, 0);
    endtask

    // Load held until the reference shows it complete; nb busy cycles in
    // the issue phase, b0 is memBusy for the other cycles.
    task automatic do_load(input logic [AW-1:0] a, input int nb,
                           input logic b0);
        logic st, b;
        int   k = 0;
        int   left = nb;
        do begin
            b = b0;
            if (ph == 1) begin
                b = (left > 0);
                if (b) left--;
            end
            step(1'b0, 1'b1, a, $urandom, b, st);
            k++;
        end while (ph != 0 && k < 60);
        if (ph != 0) chk("load_timeout", 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, lat;
        logic st;

        // Reset state
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_count", count, 0);
        chk("rst_readValid", readValid, 0);
        chk("rst_memWrite", memWrite, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle(2, 1'b0);

        // Fill and stall: four stores fit, the fifth waits for space
        for (int i = 0; i < 4; i++) do_store(32'h10 + i, 32'hD0 + i, 99, 1'b0);
        chk("fill_count", count, 4);
        do_store(32'h14, 32'hD4, 3, 1'b0);
        idle(6, 1'b0);
        chk("fill_drained", count, 0);
        chk("fill_mem_first", rd_mem(32'h10), 32'hD0);

        // Forwarding, youngest wins, port held busy
        do_store(32'h20, 32'hAAAA, 99, 1'b0);
        do_store(32'h20, 32'hBBBB, 99, 1'b0);
        do_load(32'h20, 0, 1'b1);
        chk("fwd_readValid", readValid, 1);
        chk("fwd_data", readData, 32'hBBBB);
        idle(4, 1'b0);

        // Miss priority over pending drains
        mem[32'h40]  = 32'h1234;
        arch[32'h40] = 32'h1234;
        do_store(32'h50, 32'h5050, 99, 1'b0);
        do_store(32'h51, 32'h5151, 99, 1'b0);
        t0 = $time;
        do_load(32'h40, 0, 1'b0);
        lat = ($time - t0) / 10;
        chk("miss_latency", lat, 3);
        chk("miss_data", readData, 32'h1234);
        idle(4, 1'b0);
        chk("miss_resume", count, 0);

        // Miss with the port busy for two issue cycles
        t0 = $time;
        do_load(32'h44, 2, 1'b0);
        lat = ($time - t0) / 10;
        chk("busy_latency", lat, 5);
        chk("busy_readValid", readValid, 1);
        idle(1, 1'b0);

        // Wrap-around: enqueue and drain in the same cycle
        do_store(32'h60, 32'h600, 99, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0, 32'h60 + i, 32'h600 + i, 1'b0, st);
        end
        chk("wrap_count", count, 1);
        idle(2, 1'b0);
        chk("wrap_mem_last", rd_mem(32'h69), 32'h609);

        // Simultaneous request is a store only
        do_store(32'h70, 32'h7070, 99, 1'b1);
        idle(3, 1'b0);

        // Reset mid-drain with three buffered stores
        for (int i = 0; i < 3; i++) do_store(32'h30 + i, 32'h300 + i, 99, 1'b0);
        writeIn = 1'b0;
        readIn  = 1'b0;
        memBusy = 1'b0;
        #1;
        chk("pre_rst_drain", memWrite, 1);
        chk("pre_rst_count", count, 3);
        rst = 1'b0;
        #1;
        chk("arst_memWrite", memWrite, 0);
        chk("arst_memAddress", memAddress, 0);
        chk("arst_memData", memData, 0);
        chk("arst_count", count, 0);
        chk("arst_stall", stall, 0);
        chk("arst_readData", readData, 0);
        q.delete();
        ph   = 0;
        m_rv = 1'b0;
        m_rd = '0;
        arch = mem;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle(3, 1'b0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int op;
            logic [AW-1:0] a;
            op = $urandom_range(0, 9);
            a  = 32'h100 + $urandom_range(0, 7);
            if (op < 5) begin
                do_store(a, $urandom, $urandom_range(0, 3), op == 0);
            end else if (op < 8) begin
                do_load(a, $urandom_range(0, 2), $urandom_range(0, 2) == 0);
            end else begin
                idle(1, $urandom_range(0, 1) == 0);
            end
        end
        idle(8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
